// File: rtl/alu_sequencer_if.sv
// Request/ALU/result bundle between a requester, an external ALU and alu_sequencer.
// The zero flag exists only when ALU_SEQ_ZERO_FLAG_EN is defined.
interface alu_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    start;
  logic [4:0]              op_in;
  logic [DATA_WIDTH-1:0]   a_in;
  logic [DATA_WIDTH-1:0]   b_in;
  logic [DATA_WIDTH-1:0]   alu_a;
  logic [DATA_WIDTH-1:0]   alu_b;
  logic [4:0]              alu_op;
  logic [2*DATA_WIDTH-1:0] alu_result;
  logic [DATA_WIDTH-1:0]   lo;
  logic [DATA_WIDTH-1:0]   hi;
  logic                    busy;
  logic                    done;
  logic                    error;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic                    zero;

  modport master (
    output start, op_in, a_in, b_in, alu_result,
    input  alu_a, alu_b, alu_op, lo, hi, busy, done, error, zero
  );
  modport slave (
    input  start, op_in, a_in, b_in, alu_result,
    output alu_a, alu_b, alu_op, lo, hi, busy, done, error, zero
  );
`else
  modport master (
    output start, op_in, a_in, b_in, alu_result,
    input  alu_a, alu_b, alu_op, lo, hi, busy, done, error
  );
  modport slave (
    input  start, op_in, a_in, b_in, alu_result,
    output alu_a, alu_b, alu_op, lo, hi, busy, done, error
  );
`endif
endinterface

// File: rtl/alu_sequencer.sv
// Issues one ALU operation per accepted start, waits DIV_CYCLES for divides, captures lo/hi.
// Optional zero flag on capture: define ALU_SEQ_ZERO_FLAG_EN.
module alu_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            reset,
  alu_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_e;

  localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
  logic [4:0]            alu_op_q, alu_op_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  capture;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    error_d  = error_q;
    done_d   = done_q;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          alu_a_d  = bus.a_in;
          alu_b_d  = bus.b_in;
          alu_op_d = bus.op_in;
          error_d  = 1'b0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (alu_op_q <= 5'd5) begin
          capture = 1'b1;
          done_d  = 1'b1;
          state_d = FINISH;
        end else if (alu_op_q == 5'd6) begin
          cnt_d   = DIV_LOAD;
          state_d = WAIT;
        end else begin
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = FINISH;
        end
      end
      WAIT: begin
        if (cnt_q == 8'd0) begin
          capture = 1'b1;
          done_d  = 1'b1;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      FINISH: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
    lo_d = capture ? bus.alu_result[DATA_WIDTH-1:0] : lo_q;
    hi_d = capture ? bus.alu_result[2*DATA_WIDTH-1:DATA_WIDTH] : hi_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic zero_q, zero_d;

  always_comb begin
    zero_d = capture ? (bus.alu_result == '0) : zero_q;
  end

  always_ff @(posedge clk) begin
    if (reset) zero_q <= 1'b0;
    else       zero_q <= zero_d;
  end

  assign bus.zero = zero_q;
`endif

  assign bus.alu_a  = alu_a_q;
  assign bus.alu_b  = alu_b_q;
  assign bus.alu_op = alu_op_q;
  assign bus.lo     = lo_q;
  assign bus.hi     = hi_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.error  = error_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer with a combinational ALU model
// and a transaction-level reference (expected latency, captured halves, error).
module tb_alu_sequencer;
  localparam int DW   = 32;
  localparam int DIVC = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_sequencer_if #(.DATA_WIDTH(DW)) bus();

  alu_sequencer #(.DATA_WIDTH(DW), .DIV_CYCLES(DIVC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] exp_lo, exp_hi;
  logic          exp_err, exp_zero;

  // External ALU: OR, AND, signed ADD, signed SUB, unsigned ADD, MUL, DIV (quotient low, remainder high).
  function automatic logic [2*DW-1:0] alu_fn(input logic [4:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      5'd0: return {32'd0, a | b};
      5'd1: return {32'd0, a & b};
      5'd2: return 64'(sa + sb);
      5'd3: return 64'(sa - sb);
      5'd4: return {32'd0, a} + {32'd0, b};
      5'd5: return {32'd0, a} * {32'd0, b};
      5'd6: return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: return 64'hDEAD_BEEF_0BAD_F00D;
    endcase
  endfunction

  assign bus.alu_result = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  64'(bus.busy),   64'd0);
    check({tag, "_done"},  64'(bus.done),   64'd0);
    check({tag, "_error"}, 64'(bus.error),  64'd0);
    check({tag, "_lo"},    64'(bus.lo),     64'd0);
    check({tag, "_hi"},    64'(bus.hi),     64'd0);
    check({tag, "_a"},     64'(bus.alu_a),  64'd0);
    check({tag, "_b"},     64'(bus.alu_b),  64'd0);
    check({tag, "_op"},    64'(bus.alu_op), 64'd0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    check({tag, "_zero"},  64'(bus.zero),   64'd0);
`endif
  endtask

  // One request; poke drives a conflicting start in the middle of a divide wait.
  task automatic run_txn(input logic [4:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, input bit poke);
    int lat, first_done, n_done;
    bit busy_ok, stable_ok;
    logic [2*DW-1:0] r;
    lat = (op == 5'd6) ? DIVC + 2 : 2;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_in = op;
    bus.a_in  = a;
    bus.b_in  = b;
    if (op <= 5'd6) begin
      r        = alu_fn(op, a, b);
      exp_lo   = r[DW-1:0];
      exp_hi   = r[2*DW-1:DW];
      exp_zero = (r == 0);
      exp_err  = 1'b0;
    end else begin
      exp_err  = 1'b1;
    end
    first_done = -1;
    n_done     = 0;
    busy_ok    = 1'b1;
    stable_ok  = 1'b1;
    for (int n = 1; n <= lat + 2; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        n_done++;
        if (first_done < 0) first_done = n;
      end
      if ((n <= lat) != bus.busy) busy_ok = 1'b0;
      if (n <= lat && (bus.alu_op != op || bus.alu_a != a || bus.alu_b != b)) stable_ok = 1'b0;
      if (n == lat) begin
        check("lo",    64'(bus.lo),    64'(exp_lo));
        check("hi",    64'(bus.hi),    64'(exp_hi));
        check("error", 64'(bus.error), 64'(exp_err));
`ifdef ALU_SEQ_ZERO_FLAG_EN
        check("zero",  64'(bus.zero),  64'(exp_zero));
`endif
      end
      if (poke && n == 3) begin
        bus.start = 1'b1;
        bus.op_in = ~op;
        bus.a_in  = ~a;
        bus.b_in  = ~b;
      end else begin
        bus.start = 1'b0;
      end
    end
    check("done_cycle", 64'(first_done), 64'(lat));
    check("done_count", 64'(n_done), 64'd1);
    check("busy_window", 64'(busy_ok), 64'd1);
    check("operand_hold", 64'(stable_ok), 64'd1);
    $display("[TB] op=%0d a=%h b=%h -> lo=%h hi=%h err=%0d done@%0d", op, a, b, bus.lo, bus.hi, bus.error, first_done);
  endtask

  initial begin
    int n_done;
    logic [4:0]    rop;
    logic [DW-1:0] ra, rb;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op_in = '0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    exp_lo    = '0;
    exp_hi    = '0;
    exp_err   = 1'b0;
    exp_zero  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst");
    @(negedge clk);
    reset = 1'b0;

    run_txn(5'd2, 32'd5, 32'd7, 1'b0);
    run_txn(5'd9, 32'h1234, 32'h5678, 1'b0);
    run_txn(5'd5, 32'h0001_0000, 32'h0001_0000, 1'b0);
    run_txn(5'd0, 32'd0, 32'd0, 1'b0);
    run_txn(5'd6, 32'd1000, 32'd7, 1'b0);
    run_txn(5'd6, 32'hFFFF_0000, 32'd3, 1'b1);
    run_txn(5'd3, 32'd1, 32'd2, 1'b0);

    // Reset in the middle of a divide wait aborts without done or capture.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_in = 5'd6;
    bus.a_in  = 32'd99;
    bus.b_in  = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midrst");
    exp_lo   = '0;
    exp_hi   = '0;
    exp_zero = 1'b0;
    @(negedge clk);
    reset  = 1'b0;
    n_done = 0;
    for (int i = 0; i < DIVC + 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) n_done++;
    end
    check("no_done_after_rst", 64'(n_done), 64'd0);
    run_txn(5'd2, 32'd5, 32'd7, 1'b0);

    for (int t = 0; t < 40; t++) begin
      rop = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(7, 31)) : 5'($urandom_range(0, 6));
      ra  = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rb  = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      run_txn(rop, ra, rb, (rop == 5'd6) && ($urandom_range(0, 1) == 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand width; result bus is 2*DATA_WIDTH.
REQ-002 Parameter DIV_CYCLES, default 32, cycles the sequencer waits for a divide result (legal range 1..255).
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  request strobe, sampled only in IDLE.
REQ-006 op_in  in  5  requested ALU opcode.
REQ-007 a_in, b_in  in  DATA_WIDTH each  requested operands.
REQ-008 alu_a, alu_b  out  DATA_WIDTH each  registered operands driven to the ALU.
REQ-009 alu_op  out  5  registered opcode driven to the ALU.
REQ-010 alu_result  in  2*DATA_WIDTH  ALU result, sampled by the sequencer.
REQ-011 lo, hi  out  DATA_WIDTH each  captured result low/high halves.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 error  out  1  high with done when the opcode was illegal; cleared at the next accepted start.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT, FINISH.
REQ-016 IDLE with start=1 at edge k: alu_a<=a_in, alu_b<=b_in, alu_op<=op_in, error<=0; state->ISSUE.
REQ-017 IDLE with start=0: hold all registers.
REQ-018 ISSUE, alu_op 0..5 (OR, AND, ADD, SUB, unsigned ADD, MUL): at edge k+1, lo<=alu_result[DATA_WIDTH-1:0], hi<=alu_result[2*DATA_WIDTH-1:DATA_WIDTH], done<=1; state->FINISH.
REQ-019 ISSUE, alu_op 6 (DIV): counter<=DIV_CYCLES-1; state->WAIT.
REQ-020 WAIT: counter decrements each cycle; at the edge where counter==0, capture lo/hi as in REQ-018, done<=1; state->FINISH.
REQ-021 ISSUE, alu_op 7..31: error<=1, done<=1, lo/hi unchanged; state->FINISH.
REQ-022 FINISH: done<=0; state->IDLE; error holds.
REQ-023 Latency, start sample to done high: 2 cycles for ops 0..5 and illegal ops; 2+DIV_CYCLES cycles for op 6.
REQ-024 Throughput: the next start is accepted no earlier than the cycle after done.
REQ-025 start while busy is ignored; no queueing.
REQ-026 alu_a, alu_b and alu_op hold stable from ISSUE through FINISH.
REQ-027 lo/hi hold their last captured value until the next successful capture.

Reset
REQ-028 reset=1 at any edge forces state IDLE, counter 0, and busy, done, error, lo, hi, alu_a, alu_b, alu_op all to 0.
REQ-029 Reset mid-operation, including WAIT, aborts without a done pulse or a capture.
REQ-030 reset takes priority over start on the same edge.

Configuration
REQ-031 Macro ALU_SEQ_ZERO_FLAG_EN defined: adds output zero (1 bit), loaded at every capture with 1 if alu_result==0, else 0.
REQ-032 zero resets to 0 and is unchanged on illegal ops.
REQ-033 Macro undefined: no zero port and no associated logic.

Verification
REQ-034 ADD: op 2, a=5, b=7, ALU model returns 12 -> done high 2 cycles after start; lo=12, hi=0, error=0.
REQ-035 MUL: op 5, a=0x00010000, b=0x00010000, model returns 0x1_00000000 -> hi=1, lo=0 (zero=0 if enabled).
REQ-036 DIV: op 6, DIV_CYCLES=32 -> busy for 34 cycles; done exactly 34 cycles after start; lo/hi equal the model value.
REQ-037 Illegal op: op 9 after a prior ADD result of 12 -> error=1 with done; lo=12, hi=0 unchanged.
REQ-038 start pulsed during WAIT -> ignored; exactly one done; alu_a, alu_b, alu_op unchanged.
REQ-039 reset asserted during WAIT -> next cycle idle with all outputs 0; no done pulse; a new start then completes normally.
